// File: rtl/id_ex_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_pkg
// Purpose  : Shared constants for the ID/EX pipeline register:
//            - control-vector bit positions
//            - ALUOp encodings
//            - default field widths
// Revision : 1.0  initial release
// ============================================================================
package id_ex_pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Control vector packing: {alu_src, reg_dst, reg_write, mem_read,
  //                          mem_write, mem_to_reg, branch}
  localparam int CTRL_W          = 7;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_BRANCH     = 0;

  // ALUOp encodings consumed by alu_control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage : id_ex_pipe_pkg
`default_nettype wire

// File: rtl/id_ex_pipe_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_load_use_detect
// Purpose  : Combinational load-use hazard compare.
//            Flags when the load in EX writes a register that the
//            instruction in decode reads. Register 0 never hazards.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe_load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  output logic                  stall_req_o
);

  logic w_rt_nonzero;
  logic w_rt_match;

  // Destination of the load compared against both decode sources
  always_comb begin
    w_rt_nonzero = (ex_rt_i != '0);
    w_rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
    stall_req_o  = ex_valid_i && ex_mem_read_i && id_valid_i &&
                   w_rt_nonzero && w_rt_match;
  end

endmodule : id_ex_pipe_load_use_detect
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe
// Purpose  : ID/EX pipeline register with valid bit, stall hold,
//            flush-to-bubble and load-use bubble insertion.
//            Optional macro ID_EX_PERF_CNT_EN adds the perf_bubbles and
//            perf_stalls counters.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_valid,
  input  logic [DATA_W-1:0]     ID_pc_plus4,
  input  logic [DATA_W-1:0]     ID_rs_data,
  input  logic [DATA_W-1:0]     ID_rt_data,
  input  logic [DATA_W-1:0]     ID_sign_imm,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic [5:0]            ID_funct,
  input  logic [1:0]            ID_alu_op,
  input  logic [CTRL_W-1:0]     ID_ctrl,
  input  logic                  EX_stall,
  input  logic                  EX_flush,
  output logic                  ID_stall_req,
  output logic                  EX_valid,
  output logic [DATA_W-1:0]     EX_pc_plus4,
  output logic [DATA_W-1:0]     EX_rs_data,
  output logic [DATA_W-1:0]     EX_rt_data,
  output logic [DATA_W-1:0]     EX_sign_imm,
  output logic [REG_ADDR_W-1:0] EX_rs,
  output logic [REG_ADDR_W-1:0] EX_rt,
  output logic [REG_ADDR_W-1:0] EX_rd,
  output logic [5:0]            EX_funct,
  output logic [1:0]            EX_alu_op,
  output logic [CTRL_W-1:0]     EX_ctrl
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_stalls
`endif
);

  logic                  valid_q,   valid_d;
  logic [DATA_W-1:0]     pc_q,      pc_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q,     imm_d;
  logic [REG_ADDR_W-1:0] rs_q,      rs_d;
  logic [REG_ADDR_W-1:0] rt_q,      rt_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  logic [5:0]            funct_q,   funct_d;
  logic [1:0]            alu_op_q,  alu_op_d;
  logic [CTRL_W-1:0]     ctrl_q,    ctrl_d;

  logic w_hazard;
  logic w_bubble;
  logic w_load;
  logic w_haz_bubble;

  id_ex_pipe_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
    .id_valid_i    (ID_valid),
    .ex_rt_i       (rt_q),
    .id_rs_i       (ID_rs),
    .id_rt_i       (ID_rt),
    .stall_req_o   (w_hazard)
  );

  // Edge action: flush beats stall, stall beats hazard bubble, else load
  always_comb begin
    w_haz_bubble = !EX_flush && !EX_stall && w_hazard;
    w_load       = !EX_flush && !EX_stall && !w_hazard && ID_valid;
    w_bubble     = EX_flush || (!EX_stall && !w_load);

    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    funct_d   = funct_q;
    alu_op_d  = alu_op_q;
    ctrl_d    = ctrl_q;

    if (w_bubble) begin
      // A bubble is the reset image: ALUOp 00 selects add, no side effects
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      funct_d   = '0;
      alu_op_d  = ALUOP_ADD;
      ctrl_d    = '0;
    end else if (w_load) begin
      valid_d   = 1'b1;
      pc_d      = ID_pc_plus4;
      rs_data_d = ID_rs_data;
      rt_data_d = ID_rt_data;
      imm_d     = ID_sign_imm;
      rs_d      = ID_rs;
      rt_d      = ID_rt;
      rd_d      = ID_rd;
      funct_d   = ID_funct;
      alu_op_d  = ID_alu_op;
      ctrl_d    = ID_ctrl;
    end
  end

  // Pipeline register state, reset overrides every other input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      alu_op_q  <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      funct_q   <= funct_d;
      alu_op_q  <= alu_op_d;
      ctrl_q    <= ctrl_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_stalls_q;

  // Counters for hazard bubbles and downstream hold cycles, wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_bubbles_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (w_haz_bubble) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (!EX_flush && EX_stall) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`else
  logic w_unused_haz_bubble;
  assign w_unused_haz_bubble = w_haz_bubble;
`endif

  assign ID_stall_req = w_hazard;
  assign EX_valid     = valid_q;
  assign EX_pc_plus4  = pc_q;
  assign EX_rs_data   = rs_data_q;
  assign EX_rt_data   = rt_data_q;
  assign EX_sign_imm  = imm_q;
  assign EX_rs        = rs_q;
  assign EX_rt        = rt_q;
  assign EX_rd        = rd_q;
  assign EX_funct     = funct_q;
  assign EX_alu_op    = alu_op_q;
  assign EX_ctrl      = ctrl_q;

endmodule : id_ex_pipe
`default_nettype wire

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the MIPS core.
- Captures decoded instruction fields and operands from decode and drives the EX_-prefixed signals consumed by the execute stage (alu_control takes EX_funct and EX_alu_op).
- Adds a valid bit, stall hold, flush-to-bubble and built-in load-use hazard detection that inserts one bubble and requests a decode stall.

Parameters:
DATA_W, 32, width of operand/immediate/PC fields
REG_ADDR_W, 5, register specifier width

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
ID_valid  input  1  decode slot holds a real instruction
ID_pc_plus4  input  DATA_W  PC+4 of decode instruction
ID_rs_data  input  DATA_W  rs read data
ID_rt_data  input  DATA_W  rt read data
ID_sign_imm  input  DATA_W  sign-extended immediate
ID_rs  input  REG_ADDR_W  rs specifier
ID_rt  input  REG_ADDR_W  rt specifier
ID_rd  input  REG_ADDR_W  rd specifier
ID_funct  input  6  funct field
ID_alu_op  input  2  ALUOp from main control
ID_ctrl  input  7  {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch}
EX_stall  input  1  downstream stall, hold contents
EX_flush  input  1  squash, insert bubble
ID_stall_req  output  1  load-use hazard, decode/fetch must hold
EX_valid  output  1  EX slot valid
EX_pc_plus4, EX_rs_data, EX_rt_data, EX_sign_imm  output  DATA_W each  registered copies
EX_rs, EX_rt, EX_rd  output  REG_ADDR_W each  registered copies
EX_funct  output  6  registered funct
EX_alu_op  output  2  registered ALUOp
EX_ctrl  output  7  registered control, same packing as ID_ctrl

Behaviour:
- Reset (rst_n=0 at edge): every EX_ output = 0, EX_valid = 0. Reset overrides all other inputs. Reset mid-stall or mid-hazard clears everything. ID_stall_req is combinational and reads 0 while EX_valid=0.
- Bubble = reset value: all fields zero, EX_valid = 0. EX_alu_op=00 makes alu_control select add.
- Hazard (combinational):
  - ID_stall_req = EX_valid & EX_ctrl.mem_read & ID_valid & (EX_rt != 0) & (EX_rt == ID_rs | EX_rt == ID_rt).
  - rt=0 loads never stall.
- Edge update priority, highest first:
  1. !rst_n: clear.
  2. EX_flush: bubble. Flush beats stall.
  3. EX_stall: hold all outputs unchanged.
  4. ID_stall_req: bubble. The load advances downstream; decode holds.
  5. Otherwise: load all ID_ fields. EX_valid = ID_valid. If ID_valid=0, load a bubble instead.
- Latency: one cycle ID to EX.
- A stalled load keeps ID_stall_req asserted for every stall cycle. A bubble is inserted exactly once, on the first unstalled edge. The next cycle has EX_valid=0, so the request drops automatically.
- Back-to-back hazards: each load independently yields one bubble.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds outputs perf_bubbles[31:0] and perf_stalls[31:0].
  - perf_bubbles increments on each hazard-inserted bubble (priority 4 only).
  - perf_stalls increments on each EX_stall hold cycle.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - control-vector bit indices (CTRL_ALU_SRC..CTRL_BRANCH, CTRL_W=7)
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - DATA_W/REG_ADDR_W defaults
- One natural sub-module: load_use_detect, the combinational hazard compare.

Test Plan:
- Reset: drive all ID_ inputs nonzero with rst_n=0 for 2 cycles -> all EX_ outputs 0, EX_valid=0, ID_stall_req=0.
- Pass-through: ID_valid=1, ID_funct=100010, ID_alu_op=10, ID_rs_data=0x5, ID_rd=3 -> next cycle EX_funct=100010, EX_alu_op=10, EX_rs_data=0x5, EX_rd=3, EX_valid=1.
- Load-use: EX holds lw with rt=8; ID instruction has rs=8 -> ID_stall_req=1. Next edge EX_valid=0, EX_ctrl=0. Following edge the held instruction loads and ID_stall_req=0.
- Zero register: EX lw with rt=0, ID rs=0 -> ID_stall_req=0 and normal load.
- Stall vs flush: EX_stall=1 for 3 cycles -> outputs unchanged. Then EX_stall=1 and EX_flush=1 together -> bubble.
- Stalled hazard: load-use with EX_stall=1 for 2 cycles -> ID_stall_req held at 1, outputs held. Exactly one bubble after the stall releases. With ID_EX_PERF_CNT_EN, perf_stalls=2 and perf_bubbles=1.
